mem_access_unit: RTL and testbench

CPU-side initiator for the data-memory word bus. It accepts one load/store request at a time from the execute stage over a valid/ready handshake. Each request becomes one or two word-aligned bus beats with byte write masks; requests that straddle a word boundary are split into two beats. For loads, the unit merges and sign/zero-extends the returned bytes into a single response. It sits between the pipeline's memory stage and the data memory, using the same memOp encoding as the memory: LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2.

---
 rtl/mem_access_unit.sv | 186 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator splitting unaligned accesses into word bus beats
module mem_access_unit #(
  parameter int addrWidth = 32,
  parameter int dataWidth = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   reqValid,
  output logic                   reqReady,
  input  logic [addrWidth-1:0]   reqAddr,
  input  logic [dataWidth-1:0]   reqWData,
  input  logic [2:0]             reqMemOp,
  input  logic                   reqWe,
  output logic                   respValid,
  input  logic                   respReady,
  output logic [dataWidth-1:0]   respData,
  output logic                   respErr,
  output logic                   memReq,
  input  logic                   memAck,
  output logic                   memWe,
  output logic [addrWidth-1:0]   memAddr,
  output logic [dataWidth-1:0]   memWData,
  output logic [3:0]             memWMask,
  input  logic                   memRValid,
  input  logic [dataWidth-1:0]   memRData
);

  typedef enum logic [2:0] {IDLE, ACC0, RD0, ACC1, RD1, RESP} state_t;

  state_t                 state;
  logic [1:0]             capK;
  logic [2:0]             capOp;
  logic                   capWe;
  logic                   capSplit;
  logic [addrWidth-1:0]   nextAddr;
  logic [dataWidth-1:0]   b1WData;
  logic [3:0]             b1WMask;
  logic [dataWidth-1:0]   w0;

  logic [7:0]             szMask;
  logic [7:0]             laneMask;
  logic [2*dataWidth-1:0] laneData;
  logic                   illegal;
  logic                   split;
  logic [2*dataWidth-1:0] mergeWord;
  logic [2*dataWidth-1:0] shifted;
  logic [dataWidth-1:0]   raw;
  logic [dataWidth-1:0]   loadData;

  // Only IDLE takes requests, and never while reset is held
  assign reqReady = rstn && (state == IDLE);

  // Decode the incoming request into both beats' lane masks and lane-positioned data;
  // the upper half of each 8-lane/64-bit image is what spills into the next word
  always_comb begin
    case (reqMemOp[1:0])
      2'd0:    szMask = 8'h01;
      2'd1:    szMask = 8'h03;
      default: szMask = 8'h0F;
    endcase
    laneMask = szMask << reqAddr[1:0];
    laneData = {{dataWidth{1'b0}}, reqWData} << {reqAddr[1:0], 3'b000};
    illegal  = (reqMemOp[1:0] == 2'b11) || (reqMemOp[2] && reqMemOp[1]);
    split    = |laneMask[7:4];
  end

  // Merge returned words, shift the addressed bytes down, then extend by memOp
  always_comb begin
    mergeWord = (state == RD1) ? {memRData, w0} : {{dataWidth{1'b0}}, memRData};
    shifted   = mergeWord >> {capK, 3'b000};
    raw       = shifted[dataWidth-1:0];
    case (capOp)
      3'd0:    loadData = {{24{raw[7]}}, raw[7:0]};
      3'd1:    loadData = {{16{raw[15]}}, raw[15:0]};
      3'd4:    loadData = {24'd0, raw[7:0]};
      3'd5:    loadData = {16'd0, raw[15:0]};
      default: loadData = raw;
    endcase
  end

  // Request/beat/response sequencer; all bus and response outputs are registered here
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      capK      <= '0;
      capOp     <= '0;
      capWe     <= 1'b0;
      capSplit  <= 1'b0;
      nextAddr  <= '0;
      b1WData   <= '0;
      b1WMask   <= '0;
      w0        <= '0;
      memReq    <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= '0;
      memWData  <= '0;
      memWMask  <= '0;
      respValid <= 1'b0;
      respData  <= '0;
      respErr   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (reqValid) begin
          capK     <= reqAddr[1:0];
          capOp    <= reqMemOp;
          capWe    <= reqWe;
          capSplit <= split;
          nextAddr <= {reqAddr[addrWidth-1:2], 2'b00} + 4;
          b1WData  <= reqWe ? laneData[2*dataWidth-1:dataWidth] : '0;
          b1WMask  <= reqWe ? laneMask[7:4] : 4'd0;
          if (illegal) begin
            respValid <= 1'b1;
            respErr   <= 1'b1;
            respData  <= '0;
            state     <= RESP;
          end else begin
            memReq   <= 1'b1;
            memWe    <= reqWe;
            memAddr  <= {reqAddr[addrWidth-1:2], 2'b00};
            memWData <= reqWe ? laneData[dataWidth-1:0] : '0;
            memWMask <= reqWe ? laneMask[3:0] : 4'd0;
            state    <= ACC0;
          end
        end
        ACC0: if (memAck) begin
          if (capWe && capSplit) begin
            // Store second beat goes out back-to-back; no read to wait for
            memAddr  <= nextAddr;
            memWData <= b1WData;
            memWMask <= b1WMask;
            state    <= ACC1;
          end else if (capWe) begin
            memReq    <= 1'b0;
            respValid <= 1'b1;
            respData  <= '0;
            state     <= RESP;
          end else begin
            memReq <= 1'b0;
            state  <= RD0;
          end
        end
        RD0: if (memRValid) begin
          w0 <= memRData;
          if (capSplit) begin
            memReq   <= 1'b1;
            memWe    <= 1'b0;
            memAddr  <= nextAddr;
            memWData <= '0;
            memWMask <= 4'd0;
            state    <= ACC1;
          end else begin
            respValid <= 1'b1;
            respData  <= loadData;
            state     <= RESP;
          end
        end
        ACC1: if (memAck) begin
          memReq <= 1'b0;
          if (capWe) begin
            respValid <= 1'b1;
            respData  <= '0;
            state     <= RESP;
          end else begin
            state <= RD1;
          end
        end
        RD1: if (memRValid) begin
          respValid <= 1'b1;
          respData  <= loadData;
          state     <= RESP;
        end
        RESP: if (respReady) begin
          respValid <= 1'b0;
          respData  <= '0;
          respErr   <= 1'b0;
          memWe     <= 1'b0;
          memWData  <= '0;
          memWMask  <= 4'd0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - table-driven scoreboard bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        reqValid, reqReady;
  logic [31:0] reqAddr, reqWData;
  logic [2:0]  reqMemOp;
  logic        reqWe;
  logic        respValid, respReady;
  logic [31:0] respData;
  logic        respErr;
  logic        memReq, memAck, memWe;
  logic [31:0] memAddr, memWData;
  logic [3:0]  memWMask;
  logic        memRValid;
  logic [31:0] memRData;

  mem_access_unit dut (
    .clk(clk), .rstn(rstn),
    .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr), .reqWData(reqWData),
    .reqMemOp(reqMemOp), .reqWe(reqWe),
    .respValid(respValid), .respReady(respReady), .respData(respData), .respErr(respErr),
    .memReq(memReq), .memAck(memAck), .memWe(memWe), .memAddr(memAddr),
    .memWData(memWData), .memWMask(memWMask), .memRValid(memRValid), .memRData(memRData)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr, wdata;
    logic [2:0]  op;
    logic        we;
    logic [31:0] rd0, rd1;
    int          stall, hold;
    logic [31:0] ed;
    logic        ee;
    int          lat, nbeats;
    logic [31:0] b0a, b0d;
    logic [3:0]  b0m;
    logic [31:0] b1a, b1d;
    logic [3:0]  b1m;
  } vec_t;

  typedef struct { logic [31:0] a, d; logic [3:0] m; logic we; } beat_t;
  typedef struct { logic [31:0] d; logic e; } resp_t;

  beat_t beat_q[$];
  resp_t resp_q[$];
  vec_t  vecs[13];
  int    checks = 0;
  int    errors = 0;
  int    cur = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL t%0d %s actual=%h required=%h", cur, name, act, req);
    end
  endtask

  function automatic vec_t mk(
    input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] op, input logic we,
    input logic [31:0] rd0, input logic [31:0] rd1, input int stall, input int hold,
    input logic [31:0] ed, input logic ee, input int lat, input int nbeats,
    input logic [31:0] b0a, input logic [31:0] b0d, input logic [3:0] b0m,
    input logic [31:0] b1a, input logic [31:0] b1d, input logic [3:0] b1m);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.op = op; v.we = we; v.rd0 = rd0; v.rd1 = rd1;
    v.stall = stall; v.hold = hold; v.ed = ed; v.ee = ee; v.lat = lat; v.nbeats = nbeats;
    v.b0a = b0a; v.b0d = b0d; v.b0m = b0m; v.b1a = b1a; v.b1d = b1d; v.b1m = b1m;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int    cyc;
    int    beat;
    int    stall;
    bit    rd_pend;
    bit    done;
    beat_t b;
    resp_t r;
    if (v.nbeats > 0) beat_q.push_back('{v.b0a, v.b0d, v.b0m, v.we});
    if (v.nbeats > 1) beat_q.push_back('{v.b1a, v.b1d, v.b1m, v.we});
    resp_q.push_back('{v.ed, v.ee});
    @(negedge clk);
    chk("reqReady_idle", {31'd0, reqReady}, 32'd1);
    reqValid = 1'b1; reqAddr = v.addr; reqWData = v.wdata; reqMemOp = v.op; reqWe = v.we;
    @(posedge clk);
    cyc = 0; beat = 0; stall = v.stall; rd_pend = 1'b0; done = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      reqValid = 1'b0; memAck = 1'b0; memRValid = 1'b0; memRData = '0;
      if (rd_pend) begin
        memRValid = 1'b1;
        memRData  = (beat == 1) ? v.rd0 : v.rd1;
        rd_pend   = 1'b0;
      end
      if (memReq) begin
        if (beat_q.size() == 0) begin
          chk("unexpected_beat", {31'd0, memReq}, 32'd0);
        end else begin
          b = beat_q[0];
          chk("memAddr", memAddr, b.a);
          chk("memWData", memWData, b.d);
          chk("memWMask", {28'd0, memWMask}, {28'd0, b.m});
          chk("memWe", {31'd0, memWe}, {31'd0, b.we});
          if (stall > 0) stall--;
          else begin
            memAck = 1'b1;
            void'(beat_q.pop_front());
            beat++;
            if (!b.we) rd_pend = 1'b1;
          end
        end
      end
      if (respValid) begin
        chk("latency", cyc, v.lat);
        if (resp_q.size() == 0) begin
          chk("unexpected_resp", {31'd0, respValid}, 32'd0);
          r = '{32'd0, 1'b0};
        end else r = resp_q.pop_front();
        chk("respData", respData, r.d);
        chk("respErr", {31'd0, respErr}, {31'd0, r.e});
        for (int h = 0; h < v.hold; h++) begin
          @(negedge clk);
          chk("hold_respValid", {31'd0, respValid}, 32'd1);
          chk("hold_respData", respData, r.d);
          chk("hold_respErr", {31'd0, respErr}, {31'd0, r.e});
          chk("hold_reqReady", {31'd0, reqReady}, 32'd0);
        end
        respReady = 1'b1;
        @(negedge clk);
        respReady = 1'b0;
        chk("post_respValid", {31'd0, respValid}, 32'd0);
        chk("post_respData", respData, 32'd0);
        chk("post_respErr", {31'd0, respErr}, 32'd0);
        chk("post_reqReady", {31'd0, reqReady}, 32'd1);
        done = 1'b1;
      end
    end
    if (!done) chk("timeout", cyc, v.lat);
    chk("beats_left", beat_q.size(), 0);
    beat_q.delete();
    resp_q.delete();
    memAck = 1'b0; memRValid = 1'b0; respReady = 1'b0; reqValid = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ctl"}, {23'd0, reqReady, memReq, memWe, memWMask, respValid, respErr}, 32'd0);
    chk({tag, "_memAddr"}, memAddr, 32'd0);
    chk({tag, "_memWData"}, memWData, 32'd0);
    chk({tag, "_respData"}, respData, 32'd0);
  endtask

  initial begin
    //           addr          wdata         op  we rd0           rd1           st hd exp_data      err lat nb b0a           b0d           b0m     b1a           b1d           b1m
    vecs[0]  = mk(32'h00000100, 32'h0,        0+2, 0, 32'hDEADBEEF, 32'h0,        0, 0, 32'hDEADBEEF, 0, 3, 1, 32'h00000100, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000);
    vecs[1]  = mk(32'h00000103, 32'h0,        0,   0, 32'h80112233, 32'h0,        0, 0, 32'hFFFFFF80, 0, 3, 1, 32'h00000100, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000);
    vecs[2]  = mk(32'h00000103, 32'h0,        4,   0, 32'h80112233, 32'h0,        0, 0, 32'h00000080, 0, 3, 1, 32'h00000100, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000);
    vecs[3]  = mk(32'h00000101, 32'hAABBCCDD, 2,   1, 32'h0,        32'h0,        0, 0, 32'h0,        0, 3, 2, 32'h00000100, 32'hBBCCDD00, 4'b1110, 32'h00000104, 32'h000000AA, 4'b0001);
    vecs[4]  = mk(32'hFFFFFFFF, 32'h0,        5,   0, 32'h12000000, 32'h00000034, 0, 0, 32'h00003412, 0, 5, 2, 32'hFFFFFFFC, 32'h0,        4'b0000, 32'h00000000, 32'h0,        4'b0000);
    vecs[5]  = mk(32'h00000200, 32'h0,        3,   0, 32'h0,        32'h0,        0, 3, 32'h0,        1, 1, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000);
    vecs[6]  = mk(32'h00000102, 32'h123456AB, 0,   1, 32'h0,        32'h0,        0, 0, 32'h0,        0, 2, 1, 32'h00000100, 32'h56AB0000, 4'b0100, 32'h0,        32'h0,        4'b0000);
    vecs[7]  = mk(32'h00000103, 32'h0000BEEF, 1,   1, 32'h0,        32'h0,        0, 0, 32'h0,        0, 3, 2, 32'h00000100, 32'hEF000000, 4'b1000, 32'h00000104, 32'h000000BE, 4'b0001);
    vecs[8]  = mk(32'h00000202, 32'h0,        1,   0, 32'h8001CAFE, 32'h0,        2, 0, 32'hFFFF8001, 0, 5, 1, 32'h00000200, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000);
    vecs[9]  = mk(32'h00000006, 32'h0,        2,   0, 32'h3344AAAA, 32'hBBBB1122, 0, 0, 32'h11223344, 0, 5, 2, 32'h00000004, 32'h0,        4'b0000, 32'h00000008, 32'h0,        4'b0000);
    vecs[10] = mk(32'h00000010, 32'h0,        7,   0, 32'h0,        32'h0,        0, 0, 32'h0,        1, 1, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000);
    vecs[11] = mk(32'h00000300, 32'hCAFEF00D, 2,   1, 32'h0,        32'h0,        0, 1, 32'h0,        0, 2, 1, 32'h00000300, 32'hCAFEF00D, 4'b1111, 32'h0,        32'h0,        4'b0000);
    vecs[12] = mk(32'h00000100, 32'h0,        5,   0, 32'h0000FFFF, 32'h0,        0, 0, 32'h0000FFFF, 0, 3, 1, 32'h00000100, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000);

    rstn = 1'b0; reqValid = 1'b0; reqAddr = '0; reqWData = '0; reqMemOp = '0; reqWe = 1'b0;
    respReady = 1'b0; memAck = 1'b0; memRValid = 1'b0; memRData = '0;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rstn = 1'b1;
    @(negedge clk);
    chk("release_reqReady", {31'd0, reqReady}, 32'd1);

    foreach (vecs[i]) begin
      cur = i;
      run_vec(vecs[i]);
    end

    // Reset while waiting for read data, then a stray memRValid, then a clean load
    cur = 100;
    @(negedge clk);
    reqValid = 1'b1; reqAddr = 32'h00000400; reqMemOp = 3'd2; reqWe = 1'b0;
    @(negedge clk);
    reqValid = 1'b0;
    chk("abort_memReq", {31'd0, memReq}, 32'd1);
    memAck = 1'b1;
    @(negedge clk);
    memAck = 1'b0;
    chk("abort_in_rd0", {30'd0, memReq, respValid}, 32'd0);
    rstn = 1'b0;
    @(negedge clk);
    chk_reset_outs("abort");
    rstn = 1'b1;
    @(negedge clk);
    memRValid = 1'b1; memRData = 32'h0BADF00D;
    @(negedge clk);
    memRValid = 1'b0; memRData = '0;
    chk("stray_rvalid", {29'd0, reqReady, memReq, respValid}, 32'd4);
    @(negedge clk);
    chk("stray_rvalid2", {29'd0, reqReady, memReq, respValid}, 32'd4);
    cur = 101;
    run_vec(mk(32'h00000400, 32'h0, 2, 0, 32'h01020304, 32'h0, 0, 0, 32'h01020304, 0, 3, 1,
               32'h00000400, 32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
